// File: rtl/arb_pkg.sv
// Shared types and defaults for the two-master data-RAM arbiter.
// Optional stall counters are built only when ARB_PERF_EN is defined.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } mst_e;

  localparam int unsigned MAX_HOLD_DEF = 4;

endpackage

// File: rtl/arb_sat_cnt.sv
// Saturating up-counter used for per-master stall statistics.
// Instantiated by mem_arbiter only under ARB_PERF_EN.
module arb_sat_cnt #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != '1)) begin
      o_cnt <= o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter with bounded hold for a shared data RAM.
// Define ARB_PERF_EN to build the saturating per-master stall counters.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [31:0]       i_m0_wdata,
  input  logic [3:0]        i_m0_be,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [31:0]       o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [31:0]       i_m1_wdata,
  input  logic [3:0]        i_m1_be,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [31:0]       o_m1_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_be,
  input  logic [31:0]       i_mem_rdata,
  output logic [31:0]       o_stall_cnt0,
  output logic [31:0]       o_stall_cnt1
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  arb_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  mst_e          last_q, last_d;
  logic          pend0_q, pend1_q;
  logic          drop_q;
  logic          gnt0, gnt1;
  logic          keep;

  assign keep = hold_q < HOLD_MAX;

  // drop_q blanks the first cycle after a reset that cut a read short
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst && !drop_q) begin
      unique case ({i_m0_req, i_m1_req})
        2'b10: gnt0 = 1'b1;
        2'b01: gnt1 = 1'b1;
        2'b11: begin
          unique case (state_q)
            OWN0: begin
              gnt0 = keep;
              gnt1 = !keep;
            end
            OWN1: begin
              gnt1 = keep;
              gnt0 = !keep;
            end
            default: begin
              gnt0 = (last_q == M1);
              gnt1 = (last_q == M0);
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = IDLE;
    hold_d  = '0;
    last_d  = last_q;
    if (gnt0) begin
      state_d = OWN0;
      last_d  = M0;
      if (i_m1_req) begin
        hold_d = (state_q == OWN0) ? hold_q + 1'b1
                                   : HW'(1);
      end
    end else if (gnt1) begin
      state_d = OWN1;
      last_d  = M1;
      if (i_m0_req) begin
        hold_d = (state_q == OWN1) ? hold_q + 1'b1
                                   : HW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= M1;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      drop_q  <= drop_q | pend0_q | pend1_q;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      pend0_q <= gnt0 & ~i_m0_we;
      pend1_q <= gnt1 & ~i_m1_we;
      drop_q  <= 1'b0;
    end
  end

  assign o_m0_gnt = gnt0;
  assign o_m1_gnt = gnt1;
  assign o_mem_en = gnt0 | gnt1;

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = '0;
    unique case (1'b1)
      gnt0: begin
        o_mem_we    = i_m0_we;
        o_mem_addr  = i_m0_addr;
        o_mem_wdata = i_m0_wdata;
        o_mem_be    = i_m0_be;
      end
      gnt1: begin
        o_mem_we    = i_m1_we;
        o_mem_addr  = i_m1_addr;
        o_mem_wdata = i_m1_wdata;
        o_mem_be    = i_m1_be;
      end
      default: ;
    endcase
  end

  assign o_m0_rvalid = pend0_q & ~i_rst;
  assign o_m1_rvalid = pend1_q & ~i_rst;
  assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
  assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;

`ifdef ARB_PERF_EN
  arb_sat_cnt #(.W(32)) u_stall0 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (i_m0_req & ~gnt0),
    .o_cnt (o_stall_cnt0)
  );

  arb_sat_cnt #(.W(32)) u_stall1 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (i_m1_req & ~gnt1),
    .o_cnt (o_stall_cnt1)
  );
`else
  assign o_stall_cnt0 = '0;
  assign o_stall_cnt1 = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a cycle-level reference model.
// Stall-counter expectations follow ARB_PERF_EN.
module tb_mem_arbiter;

  localparam int MAXH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_m0_req, i_m0_we;
  logic [31:0] i_m0_addr, i_m0_wdata;
  logic [3:0]  i_m0_be;
  logic        o_m0_gnt, o_m0_rvalid;
  logic [31:0] o_m0_rdata;
  logic        i_m1_req, i_m1_we;
  logic [31:0] i_m1_addr, i_m1_wdata;
  logic [3:0]  i_m1_be;
  logic        o_m1_gnt, o_m1_rvalid;
  logic [31:0] o_m1_rdata;
  logic        o_mem_en, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_stall_cnt0, o_stall_cnt1;

  int errors = 0;
  int checks = 0;
  bit run = 0;

  mem_arbiter #(.ADDR_W(32), .MAX_HOLD(MAXH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_req(i_m0_req), .i_m0_we(i_m0_we),
    .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
    .i_m0_be(i_m0_be), .o_m0_gnt(o_m0_gnt),
    .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(i_m1_req), .i_m1_we(i_m1_we),
    .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
    .i_m1_be(i_m1_be), .o_m1_gnt(o_m1_gnt),
    .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_be(o_mem_be), .i_mem_rdata(i_mem_rdata),
    .o_stall_cnt0(o_stall_cnt0), .o_stall_cnt1(o_stall_cnt1)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: who was granted last cycle, how long the
  // contested streak is, who won last, and which read is in flight.
  int     prev_g = -1;
  int     streak = 0;
  int     last_w = 1;
  int     pend   = -1;
  bit     drop   = 0;
  longint c0 = 0, c1 = 0;

  always @(negedge i_clk) begin
    int eg;
    bit ewe, oreq;
    logic [31:0] ea, ed;
    logic [3:0]  eb;
    eg = -1;
    if (!i_rst && !drop) begin
      if (i_m0_req && !i_m1_req) eg = 0;
      else if (!i_m0_req && i_m1_req) eg = 1;
      else if (i_m0_req && i_m1_req) begin
        if (prev_g < 0) eg = 1 - last_w;
        else if (streak >= MAXH) eg = 1 - prev_g;
        else eg = prev_g;
      end
    end
    ewe = 0; ea = 0; ed = 0; eb = 0;
    if (eg == 0) begin
      ewe = i_m0_we; ea = i_m0_addr;
      ed = i_m0_wdata; eb = i_m0_be;
    end else if (eg == 1) begin
      ewe = i_m1_we; ea = i_m1_addr;
      ed = i_m1_wdata; eb = i_m1_be;
    end
    if (run) begin
      chk("gnt0", o_m0_gnt, eg == 0);
      chk("gnt1", o_m1_gnt, eg == 1);
      chk("mem_en", o_mem_en, eg >= 0);
      chk("mem_we", o_mem_we, ewe);
      chk("mem_addr", o_mem_addr, ea);
      chk("mem_wdata", o_mem_wdata, ed);
      chk("mem_be", o_mem_be, eb);
      chk("rvalid0", o_m0_rvalid, pend == 0 && !i_rst);
      chk("rvalid1", o_m1_rvalid, pend == 1 && !i_rst);
      chk("rdata0", o_m0_rdata,
          (pend == 0 && !i_rst) ? i_mem_rdata : 32'h0);
      chk("rdata1", o_m1_rdata,
          (pend == 1 && !i_rst) ? i_mem_rdata : 32'h0);
`ifdef ARB_PERF_EN
      chk("stall0", o_stall_cnt0, c0);
      chk("stall1", o_stall_cnt1, c1);
`else
      chk("stall0", o_stall_cnt0, 0);
      chk("stall1", o_stall_cnt1, 0);
`endif
    end
    if (i_rst) begin
      drop = drop || (pend >= 0);
      prev_g = -1; streak = 0; last_w = 1;
      pend = -1; c0 = 0; c1 = 0;
    end else begin
      drop = 0;
      if (eg >= 0) begin
        oreq = (eg == 0) ? i_m1_req : i_m0_req;
        if (!oreq) streak = 0;
        else if (eg == prev_g) streak++;
        else streak = 1;
        last_w = eg;
      end else begin
        streak = 0;
      end
      prev_g = eg;
      pend = (eg >= 0 && !ewe) ? eg : -1;
      if (i_m0_req && eg != 0 && c0 < 64'hFFFF_FFFF) c0++;
      if (i_m1_req && eg != 1 && c1 < 64'hFFFF_FFFF) c1++;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_m0_req = 0; i_m0_we = 0; i_m0_addr = 0;
    i_m0_wdata = 0; i_m0_be = 0;
    i_m1_req = 0; i_m1_we = 0; i_m1_addr = 0;
    i_m1_wdata = 0; i_m1_be = 0;
  endtask

  task automatic both_rd();
    i_m0_req = 1; i_m0_we = 0;
    i_m0_addr = 32'h100; i_m0_be = 4'hF;
    i_m1_req = 1; i_m1_we = 0;
    i_m1_addr = 32'h200; i_m1_be = 4'hF;
  endtask

  int gseq[9];
  int exp_seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  logic [3:0] pat [12] = '{
    4'b1100, 4'b1101, 4'b0011, 4'b1111,
    4'b1111, 4'b1010, 4'b0100, 4'b1110,
    4'b0000, 4'b1011, 4'b1100, 4'b0111
  };

  initial begin
    idle();
    i_mem_rdata = 32'h0;
    i_rst = 1;
    step();
    run = 1;
    step();
    i_rst = 0;
    step();

    // lone m0 read
    i_m0_req = 1; i_m0_addr = 32'h10; i_m0_be = 4'hF;
    @(negedge i_clk);
    chk("rd_gnt0", o_m0_gnt, 1);
    step();
    idle();
    i_mem_rdata = 32'hDEADBEEF;
    @(negedge i_clk);
    chk("rd_rvalid0", o_m0_rvalid, 1);
    chk("rd_rdata0", o_m0_rdata, 32'hDEADBEEF);
    chk("rd_rvalid1", o_m1_rvalid, 0);
    step();

    // contested grant sequence from reset
    i_rst = 1;
    step();
    i_rst = 0;
    both_rd();
    for (int i = 0; i < 9; i++) begin
      i_mem_rdata = 32'hA000_0000 + i;
      @(negedge i_clk);
      gseq[i] = o_m1_gnt ? 1 : (o_m0_gnt ? 0 : 9);
      step();
    end
    for (int i = 0; i < 9; i++)
      chk($sformatf("seq%0d", i), gseq[i], exp_seq[i]);
    idle();
    step();

    // lone m1 write
    i_m1_req = 1; i_m1_we = 1; i_m1_addr = 32'h20;
    i_m1_wdata = 32'h55AA; i_m1_be = 4'hF;
    @(negedge i_clk);
    chk("wr_we", o_mem_we, 1);
    chk("wr_addr", o_mem_addr, 32'h20);
    chk("wr_wdata", o_mem_wdata, 32'h55AA);
    step();
    idle();
    @(negedge i_clk);
    chk("wr_rvalid1", o_m1_rvalid, 0);
    step();

    // back-to-back reads switching owner
    i_m0_req = 1; i_m0_addr = 32'h30;
    step();
    idle();
    i_m1_req = 1; i_m1_addr = 32'h40;
    i_mem_rdata = 32'h1111_0000;
    @(negedge i_clk);
    chk("b2b_rvalid0", o_m0_rvalid, 1);
    chk("b2b_rdata0", o_m0_rdata, 32'h1111_0000);
    step();
    idle();
    i_mem_rdata = 32'h2222_0000;
    @(negedge i_clk);
    chk("b2b_rvalid1", o_m1_rvalid, 1);
    chk("b2b_rdata1", o_m1_rdata, 32'h2222_0000);
    chk("b2b_rvalid0_low", o_m0_rvalid, 0);
    step();

    // reset right after a granted read
    i_m0_req = 1; i_m0_addr = 32'h50;
    step();
    idle();
    i_rst = 1;
    i_mem_rdata = 32'h3333_0000;
    @(negedge i_clk);
    chk("rst_rvalid0", o_m0_rvalid, 0);
    step();
    i_rst = 0;
    both_rd();
    @(negedge i_clk);
    chk("rst_drop_gnt0", o_m0_gnt, 0);
    chk("rst_drop_gnt1", o_m1_gnt, 0);
    step();
    @(negedge i_clk);
    chk("rst_tie_gnt0", o_m0_gnt, 1);
    chk("rst_tie_gnt1", o_m1_gnt, 0);
    step();
    idle();
    step();

    // m1 denied three cycles
    i_rst = 1;
    step();
    i_rst = 0;
    both_rd();
    step();
    step();
    step();
    idle();
    @(negedge i_clk);
`ifdef ARB_PERF_EN
    chk("perf_cnt1", o_stall_cnt1, 3);
`else
    chk("perf_cnt1", o_stall_cnt1, 0);
`endif
    chk("perf_cnt0", o_stall_cnt0, 0);
    step();

    // mixed request/write patterns
    for (int i = 0; i < 12; i++) begin
      logic [3:0] p;
      p = pat[i];
      i_m0_req = p[3]; i_m1_req = p[2];
      i_m0_we = p[1]; i_m1_we = p[0];
      i_m0_addr = 32'h400 + i; i_m1_addr = 32'h800 + i;
      i_m0_wdata = $urandom; i_m1_wdata = $urandom;
      i_m0_be = 4'(i); i_m1_be = 4'(~i);
      i_mem_rdata = $urandom;
      step();
    end
    idle();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width in bits.
REQ-002 SHALL have parameter MAX_HOLD, default 4, maximum consecutive grants to one master while the other master is requesting.
REQ-003 SHALL have ports i_clk in 1, system clock, and i_rst in 1, synchronous active-high reset.
REQ-004 SHALL have ports i_m0_req in 1, i_m0_we in 1, i_m0_addr in ADDR_W, i_m0_wdata in 32, i_m0_be in 4: master 0 (CPU LSU) request.
REQ-005 SHALL have ports o_m0_gnt out 1, o_m0_rvalid out 1, o_m0_rdata out 32: master 0 grant and read return.
REQ-006 SHALL have ports i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_be, o_m1_gnt, o_m1_rvalid, o_m1_rdata: master 1 (debug/DMA), same widths as master 0.
REQ-007 SHALL have ports o_mem_en out 1, o_mem_we out 1, o_mem_addr out ADDR_W, o_mem_wdata out 32, o_mem_be out 4, i_mem_rdata in 32: shared data RAM.
REQ-008 SHALL have ports o_stall_cnt0 out 32 and o_stall_cnt1 out 32: per-master denied-cycle counters (see Configuration).

Function
REQ-009 SHALL implement FSM states IDLE, OWN0 and OWN1, where OWNx means master x was granted in the previous cycle.
REQ-010 SHALL assert o_mX_gnt combinationally in any cycle in which master X's request is forwarded to memory; a transfer occurs when req and gnt are both high.
REQ-011 SHALL never assert o_m0_gnt and o_m1_gnt in the same cycle.
REQ-012 SHALL grant a lone requester in the same cycle, from any state.
REQ-013 SHALL, with both requesting from IDLE, grant the master not granted last (round-robin last_gnt bit).
REQ-014 SHALL, with both requesting in OWNx, keep granting X until X has received MAX_HOLD consecutive grants, then grant the other master in the next cycle.
REQ-015 SHALL clear the hold counter on every owner change and whenever the other master is not requesting.
REQ-016 SHALL drive o_mem_en = gnt0|gnt1, and SHALL mux we/addr/wdata/be from the granted master; when neither is granted these outputs SHALL be 0.
REQ-017 SHALL assert o_mX_rvalid exactly 1 cycle after a granted read (we=0) by X, with o_mX_rdata = i_mem_rdata in that cycle; rdata SHALL be 0 when rvalid is low.
REQ-018 SHALL never assert rvalid for a granted write.
REQ-019 SHALL transition the FSM to IDLE in the next cycle when no request is granted.
REQ-020 SHALL, for back-to-back reads that switch owner, return each rvalid to the correct master in consecutive cycles.

Reset
REQ-021 SHALL, while i_rst is high at a clock edge, set the state to IDLE, the hold counter to 0, last_gnt to 1 (master 0 wins the first tie), pending-read flags to 0 and stall counters to 0.
REQ-022 SHALL hold all gnt, rvalid, mem_en and mem_we outputs at 0 in the cycle i_rst is high and on the first cycle after reset release if reset was asserted mid-read, so that the read in flight is dropped.

Configuration
REQ-023 SHALL, when ARB_PERF_EN is defined, increment o_stall_cntX each cycle in which i_mX_req is high and o_mX_gnt is low, saturating at 0xFFFFFFFF.
REQ-024 SHALL, when ARB_PERF_EN is not defined, tie o_stall_cnt0 and o_stall_cnt1 to 0 and synthesize no counter logic.

Structure
REQ-025 SHALL place the state enum typedef (IDLE/OWN0/OWN1), the master-index typedef and the default MAX_HOLD constant in shared package arb_pkg.
REQ-026 SHALL implement each saturating stall counter as an instance of sub-module arb_sat_cnt, instantiated only under ARB_PERF_EN.

Verification
REQ-027 SHALL verify: m0 read only to addr 0x10, mem returns 0xDEADBEEF -> gnt0 same cycle, rvalid0=1 with rdata0=0xDEADBEEF 1 cycle later, rvalid1 stays 0.
REQ-028 SHALL verify: both masters request from reset -> m0 granted first; with both held high and MAX_HOLD=4, the grant sequence is 0,0,0,0,1,1,1,1,0.
REQ-029 SHALL verify: m1 write 0x55AA to 0x20 with be=0xF while m0 idle -> o_mem_we=1, o_mem_addr=0x20 and o_mem_wdata=0x55AA for one cycle, with no rvalid.
REQ-030 SHALL verify: a read granted to m0 in one cycle and to m1 in the next -> rvalid0 then rvalid1 on consecutive cycles, each carrying its own data.
REQ-031 SHALL verify: i_rst asserted in the cycle after a granted read -> no rvalid, state IDLE, and the next tie is won by m0.
REQ-032 SHALL verify: with ARB_PERF_EN, m1 denied for 3 cycles -> o_stall_cnt1=3 and o_stall_cnt0=0; without ARB_PERF_EN, both counters read 0.
